// File: rtl/xor_frame_checksum.sv
// xor_frame_checksum: XOR checksum and parity over a length-prefixed frame of words,
// held until the consumer takes it.
module xor_frame_checksum #(
   parameter int WIDTH = 8,
   parameter int LEN_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] checksum,
   output logic             parity,
   output logic             busy
);
   typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;
   state_t           state, state_n;
   logic [WIDTH-1:0] acc, acc_n;
   logic [LEN_W-1:0] cnt, cnt_n;
   logic             take;
   always_comb begin
      state_n = state;
      acc_n   = acc;
      cnt_n   = cnt;
      take    = in_valid && state == ACC;
      case (state)
         IDLE: if (start) begin
            acc_n   = '0;
            cnt_n   = len;
            state_n = (len == '0) ? HOLD : ACC;
         end
         ACC: if (take) begin
            acc_n = acc ^ in_data;
            cnt_n = cnt - 1'b1;
            if (cnt == LEN_W'(1)) state_n = HOLD;
         end
         HOLD: if (out_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         acc   <= '0;
         cnt   <= '0;
      end else begin
         state <= state_n;
         acc   <= acc_n;
         cnt   <= cnt_n;
      end
   end
   assign in_ready  = state == ACC;
   assign out_valid = state == HOLD;
   assign busy      = state != IDLE;
   assign checksum  = out_valid ? acc : '0;
   assign parity    = ^checksum;
endmodule
